echo_delay_ctrl: RTL and testbench
==================================

// Module: echo_delay_ctrl
// PURPOSE
//  Sequencer for the echo delay line. It drives one external single-port synchronous RAM as a circular buffer.
//  For each accepted input sample it performs one read (the delayed sample) and one write (the new sample).
//  It returns the sample from DELAY samples earlier on a valid/ready output.
//  It sits between the audio sample source and the echo mixer, and replaces the register-array shift delay.
// PARAMETERS
//  DATA_W     32  sample width
//  ADDR_W     8   RAM address width; depth = 2**ADDR_W; max delay = 2**ADDR_W-1
//  DELAY_RST  0   active delay after reset
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  s_valid    in   1       input sample valid
//  s_ready    out  1       input ready
//  s_data     in   DATA_W  input sample
//  cfg_load   in   1       1-cycle strobe: capture delay_cfg
//  delay_cfg  in   ADDR_W  requested delay, in samples
//  m_valid    out  1       delayed sample valid
//  m_ready    in   1       downstream ready
//  m_data     out  DATA_W  delayed sample
//  ram_en     out  1       RAM access enable
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid 1 cycle after ram_en & !ram_we
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; wp=0; fill=0; delay_act=DELAY_RST; pend=0. Reset mid-operation aborts and the in-flight sample is lost.
//  FSM: IDLE -> RD -> RD_WAIT -> WR -> OUT -> IDLE. With delay_act==0: IDLE -> WR -> OUT.
//  IDLE:
//   - s_ready=1, except when pend=1. In that cycle delay_act<=delay_pend, pend<=0, s_ready=0.
//   - On s_valid&s_ready: latch s_data into smp.
//  RD: ram_en=1, ram_we=0, ram_addr = wp - delay_act, computed mod 2**ADDR_W (wraps).
//  RD_WAIT:
//   - m_data <= (fill >= delay_act) ? ram_rdata : 0.
//   - Never-written locations therefore read as 0, so the RAM needs no clear.
//  WR:
//   - ram_en=1, ram_we=1, ram_addr=wp, ram_wdata=smp.
//   - wp<=wp+1 (wraps). fill<=fill+1, saturating at 2**ADDR_W-1.
//   - If delay_act==0: m_data<=smp.
//  OUT: m_valid=1. m_data holds stable until m_ready, then IDLE. Every ram_* output is 0 outside RD/WR.
//  Latency: accept edge -> m_valid is 4 cycles (2 cycles when delay==0). Best throughput is 1 sample per 5 cycles.
//  cfg_load:
//   - Accepted in any state: delay_pend<=delay_cfg, pend<=1.
//   - A later load overrides an earlier unapplied one.
//   - Applied only at the IDLE sample boundary, so the sample in flight uses the old delay.
//   - fill is not cleared on a delay change; data already in the RAM stays valid.
//  No output changes combinationally from inputs, except s_ready, which depends on state and pend.
// STRUCTURE
//  Package echo_pkg: DATA_W/ADDR_W defaults and the state typedef {IDLE,RD,RD_WAIT,WR,OUT}.
//  No sub-module inside. The bench and top instantiate echo_delay_ram (single-port RAM, 1-cycle read).
//  Expected size: about 150-200 RTL lines.
// TESTING
//  1. delay_cfg=3 loaded after reset; feed 1..8 -> m_data 0,0,0,1,2,3,4,5.
//  2. delay=0; feed 0xDEADBEEF -> m_data=0xDEADBEEF; m_valid 2 cycles after accept.
//  3. delay=3; hold m_ready=0 for 10 cycles in OUT -> m_data stable, s_ready=0, no RAM access.
//  4. delay=255; feed 300 samples n=1..300 -> first 255 outputs 0, then n-255 (wp wrap checked).
//  5. Load delay 3 -> 5 during RD_WAIT -> current sample uses 3, next sample uses 5, s_ready low 1 IDLE cycle.
//  6. Assert reset during WR -> all outputs 0 immediately; the next 2 samples after release read 0 (fill=0).

Source files
------------

// File: rtl/echo_pkg.sv
// Shared defaults and sequencer state encoding for the echo delay line.
package echo_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    OUT
  } state_t;

endpackage

// File: rtl/echo_delay_ram.sv
// Single-port synchronous RAM with a 1-cycle registered read, used as the delay-line store.
module echo_delay_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/echo_delay_ctrl.sv
// Circular-buffer sequencer for the echo delay line: one RAM read and one RAM write
// per accepted sample, returning the sample from delay_act samples earlier.
module echo_delay_ctrl
  import echo_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DELAY_RST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] delay_cfg,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] DELAY_INIT = ADDR_W'(DELAY_RST);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] fill;
  logic [ADDR_W-1:0] delay_act;
  logic [ADDR_W-1:0] delay_pend;
  logic              pend;
  logic [DATA_W-1:0] smp;
  logic              idle_ready;

  always_comb begin
    state_nx   = state;
    idle_ready = 1'b0;
    m_valid    = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        idle_ready = !pend;
        if (!pend && s_valid) state_nx = (delay_act == '0) ? WR : RD;
      end
      RD: begin
        ram_en   = 1'b1;
        ram_addr = wp - delay_act;
        state_nx = RD_WAIT;
      end
      RD_WAIT: state_nx = WR;
      WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wp;
        ram_wdata = smp;
        state_nx  = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gated by reset so every output reads 0 while reset is held.
  assign s_ready = idle_ready & ~reset;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wp         <= '0;
      fill       <= '0;
      delay_act  <= DELAY_INIT;
      delay_pend <= '0;
      pend       <= 1'b0;
      smp        <= '0;
      m_data     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pend) begin
        delay_act <= delay_pend;
        pend      <= 1'b0;
      end
      // A load in the same cycle as an apply stays pending for the next boundary.
      if (cfg_load) begin
        delay_pend <= delay_cfg;
        pend       <= 1'b1;
      end
      case (state)
        IDLE:    if (idle_ready && s_valid) smp <= s_data;
        RD_WAIT: m_data <= (fill >= delay_act) ? ram_rdata : '0;
        WR: begin
          wp <= wp + ADDR_W'(1);
          if (fill != '1) fill <= fill + ADDR_W'(1);
          if (delay_act == '0) m_data <= smp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed self-checking bench for echo_delay_ctrl with the single-port RAM model attached.
module tb_echo_delay_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          cfg_load = 1'b0;
  logic [AW-1:0] delay_cfg = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  echo_delay_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DELAY_RST(0)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_load(cfg_load), .delay_cfg(delay_cfg),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  echo_delay_ram #(.DATA_W(DW), .ADDR_W(AW)) ram (
    .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr),
    .wdata(ram_wdata), .rdata(ram_rdata)
  );

  task automatic load_delay(input logic [AW-1:0] d);
    cfg_load  = 1'b1;
    delay_cfg = d;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Offers one sample and returns m_data once m_valid rises; lat counts edges from the accept edge.
  task automatic send(input logic [DW-1:0] d, input bit mid, input logic [AW-1:0] mid_cfg,
                      output logic [DW-1:0] q, output int lat);
    int n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      $display("FAIL s_ready_timeout: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    s_valid = 1'b0;
    while (!m_valid && lat < 20) begin
      if (mid && lat == 2) begin
        cfg_load  = 1'b1;
        delay_cfg = mid_cfg;
      end else begin
        cfg_load = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    cfg_load = 1'b0;
    q = m_data;
  endtask

  task automatic xfer(input string name, input logic [DW-1:0] d, input logic [DW-1:0] exp,
                      input int exp_lat);
    logic [DW-1:0] q;
    int lat;
    send(d, 1'b0, '0, q, lat);
    total++;
    if (q !== exp || lat !== exp_lat)
      $display("FAIL %s: m_data=%h lat=%0d required m_data=%h lat=%0d", name, q, lat, exp, exp_lat);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({m_valid, m_data, ram_en, ram_we, ram_addr, ram_wdata, busy, s_ready} !== '0)
      $display("FAIL reset_outputs: m_valid=%b m_data=%h ram_en=%b busy=%b s_ready=%b required all 0",
               m_valid, m_data, ram_en, busy, s_ready);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: s_ready=%b busy=%b required 1 0", s_ready, busy);
    else passed++;
  endtask

  task automatic test_delay3();
    logic [DW-1:0] exp [8] = '{0, 0, 0, 1, 2, 3, 4, 5};
    load_delay(8'd3);
    for (int i = 0; i < 8; i++) xfer("delay3", DW'(i + 1), exp[i], 4);
  endtask

  task automatic test_delay0();
    load_delay(8'd0);
    xfer("delay0", 32'hDEADBEEF, 32'hDEADBEEF, 2);
  endtask

  // RAM holds 1..8 at 0..7 and DEADBEEF at 8; wp=9 with delay 3 reads address 6.
  task automatic test_backpressure();
    logic [DW-1:0] q;
    int lat;
    load_delay(8'd3);
    m_ready = 1'b0;
    send(32'h33, 1'b0, '0, q, lat);
    total++;
    if (q !== 32'd7) $display("FAIL hold_first: m_data=%h required %h", q, 32'd7);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || m_data !== 32'd7 || s_ready !== 1'b0 || ram_en !== 1'b0)
        $display("FAIL hold_cycle%0d: m_valid=%b m_data=%h s_ready=%b ram_en=%b required 1 %h 0 0",
                 i, m_valid, m_data, s_ready, ram_en, 32'd7);
      else passed++;
    end
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL hold_release: busy=%b m_valid=%b required 0 0", busy, m_valid);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp;
    apply_reset();
    load_delay(8'd255);
    for (int n = 1; n <= 300; n++) begin
      exp = (n <= 255) ? '0 : DW'(n - 255);
      xfer("wrap", DW'(n), exp, 4);
    end
  endtask

  task automatic test_cfg_midflight();
    logic [DW-1:0] q;
    int lat;
    apply_reset();
    load_delay(8'd3);
    xfer("mid_pre0", 32'h51, 32'h0, 4);
    xfer("mid_pre1", 32'h52, 32'h0, 4);
    xfer("mid_pre2", 32'h53, 32'h0, 4);
    xfer("mid_pre3", 32'h54, 32'h51, 4);
    send(32'h55, 1'b1, 8'd5, q, lat);
    total++;
    if (q !== 32'h52) $display("FAIL mid_old_delay: m_data=%h required %h", q, 32'h52);
    else passed++;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b0) $display("FAIL mid_apply_cycle: s_ready=%b required 0", s_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) $display("FAIL mid_after_apply: s_ready=%b required 1", s_ready);
    else passed++;
    xfer("mid_new_delay", 32'h56, 32'h51, 4);
  endtask

  task automatic test_reset_in_wr();
    int n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    s_valid = 1'b1;
    s_data  = 32'h66;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'd6 || ram_wdata !== 32'h66)
      $display("FAIL wr_state: ram_we=%b ram_addr=%h ram_wdata=%h required 1 06 00000066",
               ram_we, ram_addr, ram_wdata);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({m_valid, m_data, ram_en, ram_we, ram_addr, ram_wdata, busy, s_ready} !== '0)
      $display("FAIL reset_in_wr: m_valid=%b m_data=%h ram_en=%b ram_we=%b busy=%b s_ready=%b required all 0",
               m_valid, m_data, ram_en, ram_we, busy, s_ready);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_delay(8'd3);
    xfer("post_reset0", 32'hA1, 32'h0, 4);
    xfer("post_reset1", 32'hA2, 32'h0, 4);
  endtask

  initial begin
    test_reset();
    test_delay3();
    test_delay0();
    test_backpressure();
    test_wrap();
    test_cfg_midflight();
    test_reset_in_wr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
